ddr_traffic_checker: RTL
========================

Name: ddr_traffic_checker

Overview:
- Synthesizable write-then-read pattern generator and checker for the slowDDR3 user (sysIO) port.
- Sits between on-chip control/status logic and the slowDDR3 controller.
- Fills a programmable address window with a selectable data pattern, reads it back and compares every word.
- Reports pass/fail, the error count and the first mismatch.

Parameters:
- DATA_W, 16, payload width; legal values 8, 16, 32, 64.
- ADDR_W, 27, sysIO address width.
- LEN_W, 16, width of the word-count input; max run is 2^LEN_W-1 words.
- SEL_W, DATA_W/8, byte-select width.
- ERR_W, 16, error counter width; the counter saturates.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- mode  in  2  pattern select: 0 INCR, 1 INV_INCR, 2 WALK1, 3 LFSR.
- base_addr  in  ADDR_W  first word address.
- num_words  in  LEN_W  words to write/read; 0 means an immediate DONE with pass=1.
- seed  in  DATA_W  LFSR seed; a value of 0 is replaced by 1.
- init_fin  in  1  controller initialisation complete.
- wr_valid  out  1  write request.
- wr_ready  in  1  write accepted.
- wr_payload  out  DATA_W  write data.
- rd_ready  out  1  read request.
- rd_valid  in  1  read data valid.
- rd_payload  in  DATA_W  read data.
- address  out  ADDR_W  current word address.
- sel  out  SEL_W  byte select; always all-ones.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- pass  out  1  valid when done=1; high when err_count==0.
- err_count  out  ERR_W  mismatch count, saturating.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- first_err_exp  out  DATA_W  expected data at the first mismatch.
- first_err_got  out  DATA_W  read data at the first mismatch.

Behaviour:
- Reset values: all outputs 0 except sel, which is all-ones.
- Reset mid-run aborts immediately; no further requests are issued.
- FSM states: IDLE, WAIT_INIT, WRITE, READ, DONE.
- IDLE/DONE, on start:
  - latch mode, base_addr, num_words and seed;
  - clear err_count, the first_err_* registers, done and pass;
  - set busy;
  - go to WAIT_INIT, or to DONE with pass=1 if num_words==0.
  - start in any other state is ignored.
- WAIT_INIT:
  - go to WRITE the cycle after init_fin is sampled high;
  - init_fin must stay high for the whole run; if it drops, the run ends in DONE with pass=0 and err_count unchanged.
- WRITE:
  - wr_valid=1;
  - address = base_addr + idx (mod 2^ADDR_W; wrap is permitted);
  - wr_payload = pat(idx);
  - a beat completes on a cycle with wr_valid && wr_ready;
  - address and payload are stable until that beat completes, then idx increments;
  - after beat num_words-1: idx=0, regenerate the pattern from the latched seed, go to READ with no idle cycle.
- READ:
  - rd_ready=1 and address = base_addr + idx;
  - a beat completes on a cycle with rd_valid && rd_ready;
  - compare rd_payload to pat(idx) in that same cycle;
  - on mismatch:
    - err_count increments, saturating at all-ones;
    - if this is the first error, capture addr/exp/got;
  - after the last beat: DONE, busy=0, done=1, pass=(err_count==0, including the final beat).
- wr_valid and rd_ready are never high together.
- rd_valid outside READ is ignored.
- Patterns (i = idx zero-extended or truncated to DATA_W):
  - INCR = i;
  - INV_INCR = ~i;
  - WALK1 = 1 << (idx mod DATA_W);
  - LFSR:
    - Galois, per-width polynomial;
    - state = seed at the first beat;
    - advances one step per completed beat;
    - reloaded from the seed when READ starts.
- LFSR polynomials (maximal length):
  - 8: x^8+x^6+x^5+x^4+1
  - 16: x^16+x^15+x^13+x^4+1
  - 32: x^32+x^22+x^2+x+1
  - 64: x^64+x^63+x^61+x^60+1

Decomposition:
- Package ddr_tc_pkg holds:
  - the state enum;
  - the mode encodings;
  - the LFSR tap constants, indexed by DATA_W.
- Sub-module ddr_tc_patgen:
  - inputs: mode, seed, load, advance;
  - output: the current pattern word.
  - The same instance is used for the write pass and the read pass.

Test Plan:
- INCR, base=0, num_words=32768, DATA_W=16, ideal memory model, wr_ready/rd_valid always 1 after init_fin:
  - wr_payload matches address on every beat;
  - done=1, pass=1, err_count=0;
  - exactly 32768 write beats, then 32768 read beats.
- LFSR, seed=0xACE1, num_words=1000, random wr_ready/rd_valid stalls (50%):
  - payload/address are stable during stalls;
  - read-pass expected values equal the write-pass values;
  - pass=1.
- Memory model flips bit 3 at address 0x105 (base=0x100, INCR, num_words=16):
  - err_count=1, first_err_addr=0x105;
  - first_err_exp=0x0005, first_err_got=0x000D;
  - pass=0.
- base=2^27-4, num_words=8, WALK1:
  - addresses wrap 0x7FFFFFC→0x0000003;
  - data 0x0001..0x0080;
  - pass=1.
- Every read corrupted, num_words=70000 with ERR_W=16 and LEN_W=17: err_count saturates at 0xFFFF.
- Corner cases:
  - num_words=0 → DONE the cycle after start, pass=1, no requests issued;
  - start while busy is ignored;
  - resetn low mid-WRITE → all outputs 0 at once (sel all-ones), and the FSM returns to IDLE.

Source files
------------

// File: rtl/ddr_tc_pkg.sv
// Shared types and constants for the DDR traffic checker.
// State and mode encodings plus Galois LFSR feedback masks per data width.
package ddr_tc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_INCR     = 2'd0,
    M_INV_INCR = 2'd1,
    M_WALK1    = 2'd2,
    M_LFSR     = 2'd3
  } mode_t;

  // Right-shift Galois masks: bit (k-1) set for each x^k term.
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] t;
    case (w)
      8:       t = {56'd0, LFSR_TAPS_8};
      16:      t = {48'd0, LFSR_TAPS_16};
      32:      t = {32'd0, LFSR_TAPS_32};
      64:      t = LFSR_TAPS_64;
      default: t = 64'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ddr_tc_patgen.sv
// Pattern generator shared by the write and read passes.
// Ports: clk, resetn, mode, seed, load (restart), advance (one beat), pattern.
module ddr_tc_patgen
  import ddr_tc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] pattern
);

  localparam logic [DATA_W-1:0] TAPS =
    DATA_W'(lfsr_taps(DATA_W));

  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] walk;
  logic [DATA_W-1:0] lfsr;

  // All three generators run in parallel; mode only picks the output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      walk <= '0;
      lfsr <= '0;
    end else if (load) begin
      cnt  <= '0;
      walk <= DATA_W'(1);
      lfsr <= (seed == '0) ? DATA_W'(1) : seed;
    end else if (advance) begin
      cnt  <= cnt + DATA_W'(1);
      walk <= {walk[DATA_W-2:0], walk[DATA_W-1]};
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end
  end

  always_comb begin
    pattern = cnt;
    unique case (mode)
      M_INCR:     pattern = cnt;
      M_INV_INCR: pattern = ~cnt;
      M_WALK1:    pattern = walk;
      M_LFSR:     pattern = lfsr;
      default:    pattern = cnt;
    endcase
  end

endmodule

// File: rtl/ddr_traffic_checker.sv
// Write-then-read traffic generator/checker for the slowDDR3 sysIO port.
// Ports: start/mode/base_addr/num_words/seed control a run; init_fin gates
// it; wr_*/rd_*/address/sel drive the controller; busy/done/pass/err_count
// and first_err_* report the result.
module ddr_traffic_checker
  import ddr_tc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 27,
  parameter int LEN_W  = 16,
  parameter int SEL_W  = DATA_W / 8,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic [DATA_W-1:0] seed,
  input  logic              init_fin,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [DATA_W-1:0] wr_payload,
  output logic              rd_ready,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_payload,
  output logic [ADDR_W-1:0] address,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  state_t            state;
  mode_t             mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  num_q;
  logic [LEN_W-1:0]  idx;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] pg_seed;
  logic [ERR_W-1:0]  err_next;
  logic              start_ok;
  logic              last;
  logic              wr_beat;
  logic              rd_beat;
  logic              mismatch;
  logic              pg_load;
  logic              pg_adv;
  logic [ADDR_W-1:0] cur_addr;

  assign start_ok = start &&
    (state == S_IDLE || state == S_DONE);
  assign last     = (idx == num_q - LEN_W'(1));
  // A dropped init_fin aborts, so it also blocks beat completion.
  assign wr_beat  = (state == S_WRITE) && init_fin && wr_ready;
  assign rd_beat  = (state == S_READ) && init_fin && rd_valid;
  assign mismatch = (rd_payload != pat);
  assign cur_addr = base_q + ADDR_W'(idx);

  // The start load uses the live seed; the read-pass reload the latched one.
  assign pg_seed  = (state == S_WRITE) ? seed_q : seed;
  assign pg_load  = start_ok || (wr_beat && last);
  assign pg_adv   = wr_beat || rd_beat;

  always_comb begin
    err_next = err_count;
    if (mismatch && err_count != '1)
      err_next = err_count + ERR_W'(1);
  end

  ddr_tc_patgen #(
    .DATA_W (DATA_W)
  ) u_patgen (
    .clk     (clk),
    .resetn  (resetn),
    .mode    (mode_q),
    .seed    (pg_seed),
    .load    (pg_load),
    .advance (pg_adv),
    .pattern (pat)
  );

  assign wr_valid   = (state == S_WRITE);
  assign rd_ready   = (state == S_READ);
  assign wr_payload = wr_valid ? pat : '0;
  assign address    = (wr_valid || rd_ready) ? cur_addr : '0;
  assign sel        = '1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      mode_q         <= M_INCR;
      base_q         <= '0;
      num_q          <= '0;
      seed_q         <= '0;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q         <= mode_t'(mode);
            base_q         <= base_addr;
            num_q          <= num_words;
            seed_q         <= seed;
            idx            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            if (num_words == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_WAIT_INIT;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        S_WAIT_INIT: begin
          if (init_fin)
            state <= S_WRITE;
        end
        S_WRITE: begin
          if (!init_fin) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
            idx   <= '0;
          end else if (wr_ready) begin
            if (last) begin
              idx   <= '0;
              state <= S_READ;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        S_READ: begin
          if (!init_fin) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
            idx   <= '0;
          end else if (rd_valid) begin
            err_count <= err_next;
            if (mismatch && err_count == '0) begin
              first_err_addr <= cur_addr;
              first_err_exp  <= pat;
              first_err_got  <= rd_payload;
            end
            if (last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              idx   <= '0;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
